// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_core_if : configuration, serial line and status bundle of the UART receiver
// Revision 1.0
// ---------------------------------------------------------------------------
interface uart_rx_core_if;
    logic        uart_en;
    logic        uart_prty_en;
    logic        uart_rxie;
    logic [15:0] uart_baud;
    logic        uart_rxpnd_clr;
    logic        uart_rx;
    logic [7:0]  uart_rxbuf;
    logic        uart_rx9;
    logic        uart_rxpnd;
    logic        uart_ferr;
    logic        uart_ovf;
    logic        uart_rx_int;
    logic        uart_rx_busy;

    modport master (
        output uart_en, uart_prty_en, uart_rxie, uart_baud, uart_rxpnd_clr, uart_rx,
        input  uart_rxbuf, uart_rx9, uart_rxpnd, uart_ferr, uart_ovf, uart_rx_int, uart_rx_busy
    );

    modport slave (
        input  uart_en, uart_prty_en, uart_rxie, uart_baud, uart_rxpnd_clr, uart_rx,
        output uart_rxbuf, uart_rx9, uart_rxpnd, uart_ferr, uart_ovf, uart_rx_int, uart_rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_core : 16x oversampling UART receiver, 8 data bits + optional 9th bit
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_rx_core (
    input  wire logic       sys_clk,
    input  wire logic       sys_rst,
    uart_rx_core_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_BIT9  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_dly_q;
    logic [15:0] div_q, div_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        bit9_q, bit9_d;
    logic        s7_q, s7_d, s8_q, s8_d;
    logic [7:0]  rxbuf_q, rxbuf_d;
    logic        rx9_q, rx9_d;
    logic        pnd_q, pnd_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;

    logic        tick, eval, boundary, maj;

    // >= rather than == so a baud value lowered mid-frame cannot strand the divider
    assign tick     = (state_q != S_IDLE) && (div_q >= bus.uart_baud);
    assign eval     = tick && (tcnt_q == 4'd9);
    assign boundary = tick && (tcnt_q == 4'd15);
    assign maj      = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_dly_q  <= 1'b1;
            state_q   <= S_IDLE;
            div_q     <= 16'd0;
            tcnt_q    <= 4'd0;
            bitcnt_q  <= 3'd0;
            shreg_q   <= 8'h00;
            bit9_q    <= 1'b0;
            s7_q      <= 1'b0;
            s8_q      <= 1'b0;
            rxbuf_q   <= 8'h00;
            rx9_q     <= 1'b0;
            pnd_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rx_meta_q <= bus.uart_rx;
            rx_s_q    <= rx_meta_q;
            rx_dly_q  <= rx_s_q;
            state_q   <= state_d;
            div_q     <= div_d;
            tcnt_q    <= tcnt_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            bit9_q    <= bit9_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            rxbuf_q   <= rxbuf_d;
            rx9_q     <= rx9_d;
            pnd_q     <= pnd_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        bit9_d   = bit9_q;
        s7_d     = s7_q;
        s8_d     = s8_q;
        rxbuf_d  = rxbuf_q;
        rx9_d    = rx9_q;
        pnd_d    = pnd_q;
        ferr_d   = ferr_q;
        ovf_d    = ovf_q;

        if (bus.uart_rxpnd_clr) begin
            pnd_d  = 1'b0;
            ferr_d = 1'b0;
            ovf_d  = 1'b0;
        end

        if (!bus.uart_en) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (rx_dly_q && !rx_s_q) begin
                state_d = S_START;
            end
        end else begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
            if (tick) begin
                tcnt_d = tcnt_q + 4'd1;
                if (tcnt_q == 4'd7) s7_d = rx_s_q;
                if (tcnt_q == 4'd8) s8_d = rx_s_q;
            end
            case (state_q)
                S_START: begin
                    if (eval && maj) begin
                        state_d = S_IDLE;
                    end else if (boundary) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    if (eval) shreg_d = {maj, shreg_q[7:1]};
                    if (boundary) begin
                        if (bitcnt_q == 3'd7) begin
                            state_d = bus.uart_prty_en ? S_BIT9 : S_STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                S_BIT9: begin
                    if (eval) bit9_d = maj;
                    if (boundary) state_d = S_STOP;
                end
                S_STOP: begin
                    // Frame completes mid stop bit so back-to-back frames never slip
                    if (eval) begin
                        state_d = S_IDLE;
                        if (!pnd_q || bus.uart_rxpnd_clr) begin
                            rxbuf_d = shreg_q;
                            rx9_d   = bus.uart_prty_en ? bit9_q : 1'b0;
                            pnd_d   = 1'b1;
                            ferr_d  = ~maj;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_IDLE) begin
            div_d    = 16'd0;
            tcnt_d   = 4'd0;
            bitcnt_d = 3'd0;
        end
    end

    assign bus.uart_rxbuf   = rxbuf_q;
    assign bus.uart_rx9     = rx9_q;
    assign bus.uart_rxpnd   = pnd_q;
    assign bus.uart_ferr    = ferr_q;
    assign bus.uart_ovf     = ovf_q;
    assign bus.uart_rx_int  = pnd_q & bus.uart_rxie;
    assign bus.uart_rx_busy = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_core : directed and randomized frames checked against a flag-level model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_core;
    logic sys_clk;
    logic sys_rst;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_buf;
    logic       m_rx9, m_pnd, m_ferr, m_ovf;

    uart_rx_core_if ifc ();

    uart_rx_core dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (ifc.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic busy_exp);
        chk({tag, ".rxbuf"}, 16'(ifc.uart_rxbuf),   16'(m_buf));
        chk({tag, ".rx9"},   16'(ifc.uart_rx9),     16'(m_rx9));
        chk({tag, ".rxpnd"}, 16'(ifc.uart_rxpnd),   16'(m_pnd));
        chk({tag, ".ferr"},  16'(ifc.uart_ferr),    16'(m_ferr));
        chk({tag, ".ovf"},   16'(ifc.uart_ovf),     16'(m_ovf));
        chk({tag, ".int"},   16'(ifc.uart_rx_int),  16'(m_pnd & ifc.uart_rxie));
        chk({tag, ".busy"},  16'(ifc.uart_rx_busy), 16'(busy_exp));
    endtask

    task automatic model_reset();
        m_buf = 8'h00; m_rx9 = 1'b0; m_pnd = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_clear();
        m_pnd = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic b9, input logic stopv);
        if (!m_pnd) begin
            m_buf  = d;
            m_rx9  = ifc.uart_prty_en ? b9 : 1'b0;
            m_pnd  = 1'b1;
            m_ferr = ~stopv;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic pulse_clear();
        ifc.uart_rxpnd_clr = 1'b1;
        step(1);
        ifc.uart_rxpnd_clr = 1'b0;
        step(1);
        model_clear();
    endtask

    task automatic drive_bit(input logic v, input int n);
        ifc.uart_rx = v;
        step(n);
    endtask

    // spike >= 0 flips that data bit for a single cycle near its centre
    task automatic send_frame(input logic [7:0] d, input logic b9, input logic stopv,
                              input logic endv, input int spike);
        int n;
        n = 16 * (int'(ifc.uart_baud) + 1);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) begin
            if (i == spike) begin
                drive_bit(d[i], n / 2);
                drive_bit(~d[i], 1);
                drive_bit(d[i], n - n / 2 - 1);
            end else begin
                drive_bit(d[i], n);
            end
        end
        if (ifc.uart_prty_en) drive_bit(b9, n);
        drive_bit(stopv, n);
        drive_bit(endv, 4);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rb9, rstop;

        ifc.uart_en        = 1'b1;
        ifc.uart_prty_en   = 1'b0;
        ifc.uart_rxie      = 1'b1;
        ifc.uart_baud      = 16'd0;
        ifc.uart_rxpnd_clr = 1'b0;
        ifc.uart_rx        = 1'b1;
        sys_rst            = 1'b1;
        model_reset();
        step(3);
        sys_rst = 1'b0;
        step(1);
        check_all("reset", 1'b0);

        // 8N1 at one tick per cycle
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
        model_frame(8'hA5, 1'b0, 1'b1);
        check_all("a5", 1'b0);
        ifc.uart_rxie = 1'b0;
        step(1);
        chk("a5.int_masked", 16'(ifc.uart_rx_int), 16'd0);
        ifc.uart_rxie = 1'b1;
        pulse_clear();
        check_all("a5.clr", 1'b0);

        // 9-bit frame with divisor 3
        ifc.uart_baud    = 16'd3;
        ifc.uart_prty_en = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
        model_frame(8'h3C, 1'b1, 1'b1);
        check_all("3c", 1'b0);
        pulse_clear();
        check_all("3c.clr", 1'b0);

        // overrun
        ifc.uart_baud    = 16'd1;
        ifc.uart_prty_en = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, -1);
        model_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, -1);
        model_frame(8'h22, 1'b0, 1'b1);
        check_all("ovf", 1'b0);
        pulse_clear();
        check_all("ovf.clr", 1'b0);

        // framing error followed by a held break
        ifc.uart_baud = 16'd0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        model_frame(8'h55, 1'b0, 1'b0);
        check_all("ferr", 1'b0);
        pulse_clear();
        step(400);
        check_all("break", 1'b0);
        drive_bit(1'b1, 10);

        // short glitch is a false start
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 2);
        chk("glitch.busy_hi", 16'(ifc.uart_rx_busy), 16'd1);
        step(30);
        check_all("glitch", 1'b0);

        // single-cycle spike inside a data bit
        send_frame(8'h6B, 1'b0, 1'b1, 1'b1, 3);
        model_frame(8'h6B, 1'b0, 1'b1);
        check_all("spike", 1'b0);
        pulse_clear();

        // disabling mid-frame aborts reception, keeps flags
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1);
        model_frame(8'h5A, 1'b0, 1'b1);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 32);
        ifc.uart_en = 1'b0;
        step(1);
        check_all("disable", 1'b0);
        ifc.uart_en = 1'b1;
        step(200);
        check_all("reenable", 1'b0);

        // reset during data bits of 0xFF
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 48);
        chk("rst.busy_before", 16'(ifc.uart_rx_busy), 16'd1);
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        model_reset();
        check_all("midreset", 1'b0);
        step(160);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1);
        model_frame(8'h81, 1'b0, 1'b1);
        check_all("81", 1'b0);

        // randomized frames
        for (int k = 0; k < 10; k++) begin
            ifc.uart_baud    = 16'($urandom_range(0, 3));
            ifc.uart_prty_en = 1'($urandom_range(0, 1));
            rd    = 8'($urandom);
            rb9   = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_clear();
            send_frame(rd, rb9, rstop, 1'b1, -1);
            model_frame(rd, rb9, rstop);
            check_all($sformatf("rand%0d", k), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have no parameters; oversampling ratio is fixed at 16.
REQ-002 SHALL have port: sys_clk  input  1  single clock for all logic.
REQ-003 SHALL have port: sys_rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: uart_en  input  1  receiver enable.
REQ-005 SHALL have port: uart_prty_en  input  1  frame carries a 9th bit after data.
REQ-006 SHALL have port: uart_rxie  input  1  receive interrupt enable.
REQ-007 SHALL have port: uart_baud  input  16  oversample divisor; one tick every uart_baud+1 cycles.
REQ-008 SHALL have port: uart_rxpnd_clr  input  1  one-cycle pulse clearing pending/error flags.
REQ-009 SHALL have port: uart_rx  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port: uart_rxbuf  output  8  last received data byte.
REQ-011 SHALL have port: uart_rx9  output  1  last received 9th bit.
REQ-012 SHALL have port: uart_rxpnd, uart_ferr, uart_ovf  output  1 each  pending, framing error, overrun.
REQ-013 SHALL have port: uart_rx_int  output  1  equals uart_rxpnd & uart_rxie.
REQ-014 SHALL have port: uart_rx_busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL pass uart_rx through a 2-flop synchronizer (rx_s); all decisions use rx_s and its 1-cycle delayed copy.
REQ-016 SHALL implement states IDLE, START, DATA, BIT9, STOP.
REQ-017 Divider SHALL be held at 0 in IDLE, count 0..uart_baud otherwise, and emit tick when count==uart_baud; uart_baud=0 gives a tick every cycle.
REQ-018 Tick counter (4-bit) SHALL be 0 on entering START, increment per tick, wrap 15->0 marking a bit boundary.
REQ-019 IDLE->START SHALL occur on rx_s falling edge (delayed=1, rx_s=0) while uart_en=1.
REQ-020 Each bit value SHALL be the majority of rx_s sampled on ticks 7, 8, 9 of that bit; evaluated on tick 9.
REQ-021 START: if majority=1 -> IDLE (false start, no flags); else continue to bit boundary, then DATA.
REQ-022 DATA: 8 bits LSB first into a shift register; after 8th boundary -> BIT9 if uart_prty_en else STOP.
REQ-023 BIT9: capture majority as 9th bit; at boundary -> STOP.
REQ-024 STOP: on tick 9 evaluation, complete the frame the same cycle and return to IDLE (no wait for rest of stop bit).
REQ-025 Completion with uart_rxpnd=0: uart_rxbuf/uart_rx9 load, uart_rxpnd<=1, uart_ferr<=~stop_majority.
REQ-026 Completion with uart_rxpnd=1: uart_rxbuf/uart_rx9/uart_ferr unchanged, uart_ovf<=1, new frame discarded.
REQ-027 uart_rxpnd_clr SHALL clear uart_rxpnd, uart_ferr, uart_ovf next cycle.
REQ-028 Completion coinciding with uart_rxpnd_clr SHALL be treated as REQ-025 (new data loaded, rxpnd=1, ovf=0).
REQ-029 uart_rx9 SHALL load 0 when uart_prty_en=0.
REQ-030 uart_en=0 SHALL force IDLE, zero divider/tick/bit counters next cycle; flags and uart_rxbuf retained.
REQ-031 Config inputs changing mid-frame SHALL take effect immediately; no error detection for that.
REQ-032 After a framing error with line held low (break), no new START until rx_s returns high then falls.

Reset
REQ-033 sys_rst=1 at a sys_clk edge SHALL set state IDLE, all counters 0, synchronizer flops 1, uart_rxbuf=8'h00, uart_rx9=0, uart_rxpnd=0, uart_ferr=0, uart_ovf=0.
REQ-034 Reset mid-frame SHALL abandon the frame with no flag set; outputs follow REQ-033 the next cycle.

Verification
REQ-035 uart_baud=0, 8N1, send 0xA5 (16 cycles/bit) -> uart_rxbuf=0xA5, uart_rxpnd=1, uart_ferr=0, uart_rx_int=uart_rxie.
REQ-036 uart_baud=3, prty_en=1, send 0x3C with 9th bit=1 -> uart_rxbuf=0x3C, uart_rx9=1; then rxpnd_clr -> rxpnd=0.
REQ-037 Send 0x11 then 0x22 without clear -> uart_rxbuf=0x11, uart_ovf=1; rxpnd_clr -> all flags 0.
REQ-038 Stop bit driven 0 on 0x55 -> uart_rxbuf=0x55, uart_ferr=1; line held low -> no further rxpnd.
REQ-039 uart_baud=0, 5-cycle low glitch -> returns IDLE, uart_rx_busy falls, no flags; single-cycle spike mid-bit -> byte correct via majority.
REQ-040 Assert sys_rst during DATA of 0xFF -> all outputs reset values; next clean 0x81 received correctly.
